// File: rtl/ising_axi.sv
// Digital Ising-machine core: N spins, NxN coupling codes, per-spin phase
// counters and run control behind a simple register port.
module ising_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        up,
  input  logic [31:0] load_val,
  input  logic [31:0] cmax,
  output logic [31:0] ctr
);
  always_ff @(posedge clk) begin
    if (rst) ctr <= '0;
    else if (load) ctr <= load_val;
    else if (step) begin
      if (up) ctr <= (ctr >= cmax) ? cmax : ctr + 32'd1;
      else    ctr <= (ctr == '0) ? '0 : ctr - 32'd1;
    end
  end
endmodule

module ising_axi #(
  parameter int N           = 8,
  parameter int NUM_WEIGHTS = 3
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        arvalid_q,
  input  logic [31:0] araddr_q,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  input  logic        wready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wdata
);
  localparam int WW  = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int HW  = $clog2(N) + 3;
  localparam int OFF = (NUM_WEIGHTS - 1) / 2;

  logic [N-1:0][N-1:0][WW-1:0] wgt;   // wgt[i][j]: coupling of spin j into spin i
  logic [N-1:0]                diag;  // initial spins (1 = +1)
  logic [N-1:0]                spin;
  logic [N-1:0][31:0]          ctr;
  logic [31:0]                 run_cnt, cutoff, cmax;
  logic [PW-1:0]               p;
  logic signed [HW-1:0]        h;

  // write decode
  logic [10:0] wi, wj;
  logic        w_start, w_cut, w_max, w_wgt;
  assign wi      = wr_addr[12:2];
  assign wj      = wr_addr[23:13];
  assign w_start = wready && (wr_addr == 32'h0000_0000);
  assign w_cut   = wready && (wr_addr == 32'h0000_0004);
  assign w_max   = wready && (wr_addr == 32'h0000_0008);
  assign w_wgt   = wready && (wr_addr[31:24] == 8'h01) && (wr_addr[1:0] == 2'b00)
                   && (int'(wi) < N) && (int'(wj) < N);

  logic running, load, step;
  assign running = (run_cnt != '0);
  assign load    = w_start && (wdata != '0);
  assign step    = running && !w_start;

  always_ff @(posedge clk) begin
    if (axi_rstn) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          wgt[i][j] <= (i == j) ? '0 : WW'(3'b010);
      diag <= '0;
    end else if (w_wgt) begin
      if (wi == wj) diag[wi[PW-1:0]] <= wdata[0];
      else          wgt[wi[PW-1:0]][wj[PW-1:0]] <= wdata[WW-1:0];
    end
  end

  function automatic logic signed [HW-1:0] wval(input logic [WW-1:0] c);
    return $signed(HW'(c)) - $signed(HW'(OFF));
  endfunction

  // local field of the spin being updated this cycle
  always_comb begin
    h = '0;
    for (int j = 0; j < N; j++)
      if (j != int'(p)) begin
        if (spin[j]) h = h + wval(wgt[p][j]);
        else         h = h - wval(wgt[p][j]);
      end
  end

  always_ff @(posedge clk) begin
    if (axi_rstn) begin
      spin    <= '0;
      run_cnt <= '0;
      p       <= '0;
      cutoff  <= 32'd4;
      cmax    <= 32'd8;
    end else begin
      if (w_cut) cutoff <= wdata;
      if (w_max) cmax   <= wdata;
      if (w_start) begin
        run_cnt <= wdata;
        if (load) begin
          spin <= diag;
          p    <= '0;
        end
      end else if (step) begin
        run_cnt <= run_cnt - 32'd1;
        p       <= (p == PW'(N - 1)) ? '0 : p + PW'(1);
        if (!h[HW-1] && (h != '0)) spin[p] <= 1'b1;
        else if (h[HW-1])          spin[p] <= 1'b0;
      end
    end
  end

  logic [31:0] ld_val;
  assign ld_val = (cutoff > cmax) ? cmax : cutoff;

  for (genvar g = 0; g < N; g++) begin : g_ctr
    ising_ctr u_ctr (
      .clk      (clk),
      .rst      (axi_rstn),
      .load     (load),
      .step     (step),
      .up       (spin[g]),
      .load_val (ld_val),
      .cmax     (cmax),
      .ctr      (ctr[g])
    );
  end

  // read decode
  logic [10:0] ri, rj;
  logic [9:0]  pi;
  logic [31:0] rd_val;
  logic        rd_err;
  assign ri = araddr_q[12:2];
  assign rj = araddr_q[23:13];
  assign pi = araddr_q[11:2];

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if (araddr_q == 32'h0000_0000)      rd_val = run_cnt;
    else if (araddr_q == 32'h0000_0004) rd_val = cutoff;
    else if (araddr_q == 32'h0000_0008) rd_val = cmax;
    else if ((araddr_q[31:12] == 20'h00001) && (araddr_q[1:0] == 2'b00) && (int'(pi) < N))
      rd_val = ctr[pi[PW-1:0]];
    else if ((araddr_q[31:24] == 8'h01) && (araddr_q[1:0] == 2'b00)
             && (int'(ri) < N) && (int'(rj) < N)) begin
      if (ri == rj) rd_val = {31'd0, diag[ri[PW-1:0]]};
      else          rd_val = 32'(wgt[ri[PW-1:0]][rj[PW-1:0]]);
    end else rd_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (axi_rstn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (arvalid_q) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (rready) rvalid <= 1'b0;
  end
endmodule

// File: tb/tb_ising_axi.sv
// Scoreboard bench for ising_axi: expected reads are queued as stimulus is
// driven, then popped and compared as the register port returns data.
module tb_ising_axi;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        axi_rstn = 1'b1;
  logic        arvalid_q = 1'b0;
  logic [31:0] araddr_q = '0;
  logic        rready = 1'b1;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        wready = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wdata = '0;

  ising_axi #(.N(N), .NUM_WEIGHTS(3)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .arvalid_q(arvalid_q), .araddr_q(araddr_q),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] wa(input int i, input int j);
    return 32'h0100_0000 + 32'(i << 2) + 32'(j << 13);
  endfunction
  function automatic logic [31:0] pa(input int i);
    return 32'h0000_1000 + 32'(i << 2);
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] r, input string nm);
    exp_t e;
    e.addr = a; e.data = d; e.resp = r; e.name = nm;
    return e;
  endfunction

  // all tasks start and end just after a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic strobe);
    wready = strobe; wr_addr = a; wdata = d;
    @(negedge clk);
    wready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                    output logic v);
    arvalid_q = 1'b1; araddr_q = a;
    @(posedge clk); #1;
    d = rdata; r = rresp; v = rvalid;
    @(negedge clk);
    arvalid_q = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r; logic v;
    axi_rstn = 1'b1;
    idle(2);
    axi_rstn = 1'b0;
    n_vec++;
    if (rvalid !== 1'b0 || rdata !== 32'd0 || rresp !== 2'b00) begin
      n_err++;
      $display("FAIL reset_outputs: got rvalid=%b rdata=%h rresp=%b, want 0/0/00", rvalid, rdata, rresp);
    end
    sb.push_back(mk(wa(0, 1), 32'd2, 2'b00, "rst_w01"));
    sb.push_back(mk(wa(1, 1), 32'd0, 2'b00, "rst_diag11"));
    sb.push_back(mk(32'h8, 32'd8, 2'b00, "rst_ctrmax"));
    sb.push_back(mk(32'h4, 32'd4, 2'b00, "rst_cutoff"));
    sb.push_back(mk(32'h0, 32'd0, 2'b00, "rst_start"));
    sb.push_back(mk(pa(3), 32'd0, 2'b00, "rst_phase3"));
    sb.push_back(mk(32'h0000_0FF0, 32'd0, 2'b10, "unmapped"));
    sb.push_back(mk(pa(N), 32'd0, 2'b10, "phase_oob"));
    sb.push_back(mk(wa(N, 0), 32'd0, 2'b10, "wgt_oob"));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rvalid_clear: got rvalid=%b, want 0", rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_write_strobe;
    logic [31:0] d; logic [1:0] r; logic v;
    wr(wa(0, 1), 32'd0, 1'b1);
    sb.push_back(mk(wa(0, 1), 32'd0, 2'b00, "w01_written"));
    wr(wa(0, 1), 32'd2, 1'b0);
    sb.push_back(mk(wa(0, 1), 32'd0, 2'b00, "w01_nostrobe"));
    wr(wa(2, 2), 32'd1, 1'b1);
    sb.push_back(mk(wa(2, 2), 32'd1, 2'b00, "diag22_written"));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
    wr(wa(0, 1), 32'd2, 1'b1);
    wr(wa(2, 2), 32'd0, 1'b1);
  endtask

  task automatic test_all_down;
    logic [31:0] d; logic [1:0] r; logic v;
    wr(32'h4, 32'd4, 1'b1);
    wr(32'h8, 32'd8, 1'b1);
    wr(32'h0, 32'h10, 1'b1);
    idle(20);
    for (int i = 0; i < N; i++) sb.push_back(mk(pa(i), 32'd0, 2'b00, $sformatf("down_phase%0d", i)));
    sb.push_back(mk(32'h0, 32'd0, 2'b00, "down_start"));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
  endtask

  task automatic test_all_up;
    logic [31:0] d; logic [1:0] r; logic v;
    for (int i = 0; i < N; i++) wr(wa(i, i), 32'd1, 1'b1);
    wr(32'h0, 32'h10, 1'b1);
    idle(20);
    for (int i = 0; i < N; i++) sb.push_back(mk(pa(i), 32'd8, 2'b00, $sformatf("up_phase%0d", i)));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
  endtask

  // spins 0 and 1 anti-coupled, all else uncoupled: spin 0 flips, spin 1 holds
  task automatic test_frustrated;
    logic [31:0] d; logic [1:0] r; logic v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j) wr(wa(i, j), ((i + j) == 1) ? 32'd0 : 32'd1, 1'b1);
    wr(32'h0, 32'h10, 1'b1);
    idle(20);
    for (int i = 0; i < N; i++)
      sb.push_back(mk(pa(i), (i == 0) ? 32'd0 : 32'd8, 2'b00, $sformatf("frus_phase%0d", i)));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
  endtask

  task automatic test_restart;
    logic [31:0] d; logic [1:0] r; logic v;
    wr(32'h0, 32'h100, 1'b1);
    idle(10);
    wr(32'h0, 32'h10, 1'b1);
    sb.push_back(mk(pa(0), 32'd4, 2'b00, "restart_reload"));
    sb.push_back(mk(32'h0, 32'd15, 2'b00, "restart_cnt"));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
    idle(16);
    sb.push_back(mk(32'h0, 32'd0, 2'b00, "restart_done"));
    sb.push_back(mk(pa(1), 32'd8, 2'b00, "restart_phase1"));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d; logic [1:0] r; logic v;
    wr(32'h4, 32'd6, 1'b1);
    wr(32'h8, 32'd12, 1'b1);
    wr(32'h0, 32'h100, 1'b1);
    idle(5);
    axi_rstn = 1'b1;
    @(negedge clk);
    axi_rstn = 1'b0;
    sb.push_back(mk(32'h0, 32'd0, 2'b00, "mid_start"));
    sb.push_back(mk(32'h4, 32'd4, 2'b00, "mid_cutoff"));
    sb.push_back(mk(32'h8, 32'd8, 2'b00, "mid_ctrmax"));
    sb.push_back(mk(pa(1), 32'd0, 2'b00, "mid_phase1"));
    sb.push_back(mk(wa(3, 0), 32'd2, 2'b00, "mid_w30"));
    sb.push_back(mk(wa(4, 4), 32'd0, 2'b00, "mid_diag44"));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      rd(e.addr, d, r, v);
      n_vec++;
      if (d !== e.data || r !== e.resp || v !== 1'b1) begin
        n_err++;
        $display("FAIL %s: got data=%h resp=%b valid=%b, want data=%h resp=%b valid=1", e.name, d, r, v, e.data, e.resp);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_strobe();
    test_all_down();
    test_all_up();
    test_frustrated();
    test_restart();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ising_axi.md
Name: ising_axi

Overview:
- Memory-mapped digital Ising-machine core: N spins, an N×N coupling-weight array, per-spin phase counters and run control, all behind a simple AXI-lite-style register port.
- Software programs weights and initial spins, starts a run of a given cycle count, then reads the phase counters to obtain the solved spin assignment (e.g. max-cut partitions).
- Sits under the host AXI bridge; address macros START_ADDR, CTR_CUTOFF_ADDR, CTR_MAX_ADDR, PHASE_ADDR_BASE and WEIGHT_ADDR_BASE come from the shared address header.

Parameters:
- N, 8: number of spins. Max 1024.
- NUM_WEIGHTS, 3: number of weight levels. Code c maps to signed value c − (NUM_WEIGHTS−1)/2, so for 3 levels: 0=−1, 1=0, 2=+1. Code width is clog2(NUM_WEIGHTS).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- axi_rstn  in  1  reset, synchronous, active-high (asserted = 1).
- arvalid_q  in  1  read address valid.
- araddr_q  in  32  read address.
- rready  in  1  read data accepted.
- rvalid  out  1  read data valid.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rdata  out  32  read data.
- wready  in  1  write strobe.
- wr_addr  in  32  write address.
- wdata  in  32  write data.

Behaviour:
- Address map:
  - START_ADDR = 0x0000_0000.
  - CTR_CUTOFF_ADDR = 0x0000_0004.
  - CTR_MAX_ADDR = 0x0000_0008.
  - PHASE_ADDR_BASE = 0x0000_1000; phase i at +(i<<2).
  - WEIGHT_ADDR_BASE = 0x0100_0000; cell (i,j) at +(i<<2)+(j<<13), with i = addr[12:2] and j = addr[23:13].
- Reset values:
  - rvalid=0, rresp=0, rdata=0.
  - ctr_cutoff=4, ctr_max=8, run_cnt=0, all spins −1, phase counters 0.
  - Off-diagonal weight codes = 3'b010; diagonal bits = 0.
- Write:
  - On a clk edge with wready=1, wdata is written to the register at wr_addr.
  - wready=0 means no write. Unmapped writes and i or j ≥ N are ignored.
- Read:
  - On an edge with arvalid_q=1, rdata/rresp are registered from araddr_q. Result is visible after that edge (1-cycle latency).
  - rvalid is set on that edge and cleared on an edge with rready=1 and arvalid_q=0.
  - rdata updates regardless of rready.
  - Unmapped address or index ≥ N returns rdata=0, rresp=10.
- Weight cells:
  - Off-diagonal (i≠j) stores the code in wdata[clog2(NUM_WEIGHTS)−1:0]; it is the coupling of spin j into spin i's field. Not symmetrised; software writes both halves.
  - Diagonal (i,i) stores the initial spin in wdata[0] (1=+1, 0=−1).
  - Readback is zero-extended.
- CTR_CUTOFF/CTR_MAX: 32-bit read/write.
- START:
  - Write V≠0: on that edge spins load from the diagonal bits, all phase counters load ctr_cutoff (clamped to ctr_max), run_cnt=V.
  - Write 0: run_cnt=0 (abort, freeze state).
  - Read returns run_cnt.
  - A write during a run restarts the run.
- Run (each cycle while run_cnt>0):
  - p = cycle index mod N (starts at 0 on start).
  - h_p = Σ_{j≠p} w_pj·s_j, signed, width clog2(N)+3.
  - s_p ← +1 if h_p>0, −1 if h_p<0, unchanged if 0.
  - Every phase counter steps from the pre-update spins: +1 if s_i=+1, saturating at ctr_max; −1 otherwise, saturating at 0.
  - run_cnt decrements; at 0 all state freezes.
- Phase read returns counter i zero-extended to 32 bits. Value ≥ ctr_cutoff is interpreted as spin +1.
- Weight writes during a run take effect on the next update cycle.
- Reset mid-run returns everything to reset values on that edge.

Test Plan:
- Reset, then read weight (0,1), diag (1,1), CTR_MAX and 0x0000_0FF0 → rdata[2:0]=010 with rresp 00; 0; 8; rdata 0 with rresp 10. Each result 1 cycle after the address.
- Write weight (0,1)=0 with wready=1 → readback 0. Repeat with wready=0 and data 2 → readback stays 0.
- After reset (all couplings +1, spins −1), set CTR_CUTOFF=4, CTR_MAX=8, START=0x10 → after 16 cycles every phase reads 0 and START reads 0.
- Set all diagonals to 1, START=0x10 → all phases read 8.
- All off-diagonal codes 1 except (0,1)=(1,0)=0; diag0=1, diag1=1; START=0x10 → phase0=0, phase1=8.
- START=0x100, after 10 cycles START=0x10 → counters reload to 4 and the run ends after 16 more cycles (START reads 0). axi_rstn=1 mid-run → all registers return to reset values.
